rx_dma_pkt_sched: RTL and testbench
===================================

Name: rx_dma_pkt_sched

Overview:
Per-packet scheduler for the rx_intf to DMA (m00_axis) path. It queues a descriptor for every packet the PHY finishes writing into the rx buffer. For the head packet it waits for the XPU forward/block decision, then issues either a transfer-start or a drop command to the rx buffer read side. It tracks transfer completion with a watchdog so that a stalled DMA cannot hang the receive path.

Parameters:
- DESC_DEPTH, 4: descriptor FIFO depth; must be a power of 2.
- HDR_WORDS, 2: 64-bit header words prepended to every packet in the DMA stream.
- TO_WIDTH, 20: width of the timeout counter and of cfg_timeout.

Ports:
- m00_axis_aclk, in, 1: block clock.
- m00_axis_aresetn, in, 1: asynchronous active-low reset.
- cfg_enable, in, 1: allows new transfers to be launched.
- cfg_start_mode, in, 1: 0 = launch on FCS completion with no XPU decision; 1 = wait for the XPU decision.
- cfg_timeout, in, TO_WIDTH: watchdog limit in cycles; 0 disables the watchdog.
- pkt_done_strobe, in, 1: one-cycle pulse when a packet has been fully written (fcs_in_strobe).
- pkt_len, in, 16: packet length in bytes; sampled with pkt_done_strobe.
- fcs_ok, in, 1: FCS status; sampled with pkt_done_strobe.
- block_rx_dma_to_ps, in, 1: XPU decision; 1 = drop.
- block_rx_dma_to_ps_valid, in, 1: one-cycle decision strobe.
- trans_done, in, 1: final beat accepted (tvalid & tready & tlast).
- trans_start, out, 1: one-cycle launch pulse.
- trans_num_words, out, 14: 64-bit word count for the launched packet.
- trans_drop, out, 1: one-cycle pulse to discard the head packet from the buffer.
- trans_fcs_ok, out, 1: FCS status of the head descriptor.
- pending_count, out, $clog2(DESC_DEPTH)+1: number of queued descriptors.
- busy, out, 1: state is not IDLE.
- timeout_pulse, out, 1: one-cycle pulse when the watchdog fires.
- overflow_cnt, out, 8: saturating count of descriptors lost to a full FIFO.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, latched decision cleared.
- Descriptor push:
  - A push on pkt_done_strobe stores {pkt_len, fcs_ok}.
  - If the FIFO is full, the descriptor is discarded and overflow_cnt increments, saturating at 255.
  - Push and pop in the same cycle are allowed; pending_count is unchanged.
- Decision latch:
  - block_rx_dma_to_ps_valid loads a 1-entry {valid, block} register in any state.
  - A newer strobe overwrites an unconsumed one.
  - In WAIT_DEC, a strobe arriving in the same cycle is used directly and is not latched.
- Word count: trans_num_words = HDR_WORDS + ceil(pkt_len/8).
  - Computed as (pkt_len+7)>>3 in 17-bit arithmetic, then truncated to 14 bits.
  - pkt_len=0 gives HDR_WORDS.
- IDLE:
  - Stays here while the FIFO is empty or cfg_enable=0.
  - Otherwise goes to START if cfg_start_mode=0, or to WAIT_DEC if cfg_start_mode=1.
- WAIT_DEC:
  - On a decision (latched or same-cycle), consume it and go to DROP if block=1, otherwise START.
  - If the watchdog expires first, go to DROP and pulse timeout_pulse.
- START:
  - trans_start=1 for exactly one cycle, with trans_num_words and trans_fcs_ok valid during that cycle.
  - Next state is XFER.
- XFER:
  - Waits for trans_done, then pops the descriptor and returns to IDLE.
  - On watchdog expiry: pop, pulse timeout_pulse, return to IDLE.
  - trans_done in any other state is ignored.
- DROP: trans_drop=1 for one cycle, pop, return to IDLE.
- Latency:
  - Push at cycle N into an empty FIFO, IDLE, mode 0: trans_start is high at N+2.
  - Mode 1, already in WAIT_DEC, decision at cycle M: trans_start or trans_drop is high at M+1.
- Watchdog:
  - Counter clears on every state entry and counts while in WAIT_DEC or XFER.
  - Fires when count == cfg_timeout-1 and cfg_timeout != 0.
- cfg_enable deassertion: a transfer already past IDLE completes normally; descriptors keep queueing.
- A cfg_start_mode change takes effect only in IDLE.

Optional Feature:
- Macro: RX_DMA_SCHED_FCS_FILTER_EN.
- Defined: a head descriptor with fcs_ok=0 goes IDLE→DROP directly, with no decision wait and no START. Any latched decision is left intact for the next packet.
- Undefined: fcs_ok only propagates to trans_fcs_ok; scheduling is identical for good and bad FCS.

Decomposition:
- Package rx_dma_sched_pkg holds:
  - the state enum (IDLE, WAIT_DEC, START, XFER, DROP);
  - the descriptor struct {len[15:0], fcs_ok};
  - the 64-bit word size constant, 8 bytes.
- One sub-module, rx_desc_fifo: a synchronous-register FIFO with count, full and empty outputs, reused as-is.

Test Plan:
1. Mode 0, pulse pkt_done with pkt_len=128, fcs_ok=1 → trans_start 2 cycles later with trans_num_words=18; trans_done → busy=0, pending_count=0.
2. Mode 1, pkt_len=100, decision block=1 → trans_drop pulse, no trans_start. Repeat with block=0 → trans_start with trans_num_words=15.
3. Decision strobe 10 cycles before pkt_done (mode 1) → latched; trans_start 3 cycles after pkt_done.
4. cfg_timeout=50, no trans_done after trans_start → timeout_pulse 50 cycles into XFER, then IDLE with the descriptor popped.
5. Five pkt_done pulses with DESC_DEPTH=4 and cfg_enable=0 → pending_count=4, overflow_cnt=1. Set cfg_enable=1 → four launches in FIFO order.
6. With FCS_FILTER_EN defined, a pkt_done with fcs_ok=0 in mode 1 → trans_drop without any decision; without the macro → waits in WAIT_DEC.

Source files
------------

// File: rtl/rx_dma_sched_pkg.sv
// Shared types and helpers for the rx_intf -> DMA packet scheduler.
package rx_dma_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitDec,
    StStart,
    StXfer,
    StDrop
  } sched_state_e;

  typedef struct packed {
    logic [15:0] len;
    logic        fcs_ok;
  } rx_desc_t;

  localparam int unsigned WordBytes = 8;

  // Header words plus ceil(len / WordBytes), kept in 17 bits so len + 7 cannot wrap.
  function automatic logic [13:0] calc_words(input logic [15:0] len,
                                             input int unsigned hdr_words);
    logic [16:0] w;
    w = ({1'b0, len} + 17'(WordBytes - 1)) >> $clog2(WordBytes);
    w = w + 17'(hdr_words);
    return w[13:0];
  endfunction

endpackage

// File: rtl/rx_desc_fifo.sv
// Register-based descriptor FIFO with occupancy count. Depth must be a power of 2 (>= 2).
module rx_desc_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 17
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop_ok) count_d = count_q + CntW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rx_dma_pkt_sched.sv
// Per-packet rx buffer -> DMA scheduler: queues descriptors, waits for the XPU decision, launches
// or drops the head packet, and guards transfers with a watchdog. Option: RX_DMA_SCHED_FCS_FILTER_EN.
module rx_dma_pkt_sched
  import rx_dma_sched_pkg::*;
#(
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned HDR_WORDS  = 2,
  parameter int unsigned TO_WIDTH   = 20
) (
  input  logic                        m00_axis_aclk,
  input  logic                        m00_axis_aresetn,
  input  logic                        cfg_enable,
  input  logic                        cfg_start_mode,
  input  logic [TO_WIDTH-1:0]         cfg_timeout,
  input  logic                        pkt_done_strobe,
  input  logic [15:0]                 pkt_len,
  input  logic                        fcs_ok,
  input  logic                        block_rx_dma_to_ps,
  input  logic                        block_rx_dma_to_ps_valid,
  input  logic                        trans_done,
  output logic                        trans_start,
  output logic [13:0]                 trans_num_words,
  output logic                        trans_drop,
  output logic                        trans_fcs_ok,
  output logic [$clog2(DESC_DEPTH):0] pending_count,
  output logic                        busy,
  output logic                        timeout_pulse,
  output logic [7:0]                  overflow_cnt
);

  sched_state_e        state_q, state_d;
  rx_desc_t            push_desc, head_desc;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic                dec_valid_q, dec_valid_d;
  logic                dec_block_q, dec_block_d;
  logic                dec_take, dec_present, dec_block;
  logic [TO_WIDTH-1:0] wd_q, wd_d;
  logic                wd_fire;
  logic [7:0]          ovf_q, ovf_d;

  assign push_desc = '{len: pkt_len, fcs_ok: fcs_ok};

  rx_desc_fifo #(
    .Depth (DESC_DEPTH),
    .Width ($bits(rx_desc_t))
  ) u_desc_fifo (
    .clk_i   (m00_axis_aclk),
    .rst_ni  (m00_axis_aresetn),
    .push_i  (pkt_done_strobe),
    .wdata_i (push_desc),
    .pop_i   (fifo_pop),
    .rdata_o (head_desc),
    .count_o (pending_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ovf_d = (pkt_done_strobe && fifo_full && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;

  // A same-cycle strobe is newer than anything latched, so it wins.
  assign dec_present = block_rx_dma_to_ps_valid | dec_valid_q;
  assign dec_block   = block_rx_dma_to_ps_valid ? block_rx_dma_to_ps : dec_block_q;

  assign wd_fire = (cfg_timeout != '0) && (wd_q == cfg_timeout - TO_WIDTH'(1)) &&
                   (state_q == StWaitDec || state_q == StXfer);

  always_comb begin
    state_d       = state_q;
    trans_start   = 1'b0;
    trans_drop    = 1'b0;
    timeout_pulse = 1'b0;
    fifo_pop      = 1'b0;
    dec_take      = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty && cfg_enable) begin
          state_d = cfg_start_mode ? StWaitDec : StStart;
`ifdef RX_DMA_SCHED_FCS_FILTER_EN
          if (!head_desc.fcs_ok) state_d = StDrop;
`endif
        end
      end
      StWaitDec: begin
        if (dec_present) begin
          dec_take = 1'b1;
          state_d  = dec_block ? StDrop : StStart;
        end else if (wd_fire) begin
          timeout_pulse = 1'b1;
          state_d       = StDrop;
        end
      end
      StStart: begin
        trans_start = 1'b1;
        state_d     = StXfer;
      end
      StXfer: begin
        if (trans_done) begin
          fifo_pop = 1'b1;
          state_d  = StIdle;
        end else if (wd_fire) begin
          fifo_pop      = 1'b1;
          timeout_pulse = 1'b1;
          state_d       = StIdle;
        end
      end
      StDrop: begin
        trans_drop = 1'b1;
        fifo_pop   = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes seen in WaitDec are consumed directly and never latched.
  always_comb begin
    dec_valid_d = dec_valid_q;
    dec_block_d = dec_block_q;
    if (dec_take) dec_valid_d = 1'b0;
    if (block_rx_dma_to_ps_valid && state_q != StWaitDec) begin
      dec_valid_d = 1'b1;
      dec_block_d = block_rx_dma_to_ps;
    end
  end

  always_comb begin
    wd_d = '0;
    if (state_d == state_q && (state_q == StWaitDec || state_q == StXfer)) begin
      wd_d = wd_q + TO_WIDTH'(1);
    end
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q     <= StIdle;
      dec_valid_q <= 1'b0;
      dec_block_q <= 1'b0;
      wd_q        <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      dec_valid_q <= dec_valid_d;
      dec_block_q <= dec_block_d;
      wd_q        <= wd_d;
      ovf_q       <= ovf_d;
    end
  end

  assign trans_num_words = fifo_empty ? '0 : calc_words(head_desc.len, HDR_WORDS);
  assign trans_fcs_ok    = ~fifo_empty & head_desc.fcs_ok;
  assign busy            = (state_q != StIdle);
  assign overflow_cnt    = ovf_q;

endmodule

// File: tb/tb_rx_dma_pkt_sched.sv
// Self-checking bench for rx_dma_pkt_sched: directed scenarios plus a randomized queue-model run.
module tb_rx_dma_pkt_sched;

  localparam int unsigned DescDepth = 4;
  localparam int unsigned HdrWords  = 2;
  localparam int unsigned ToWidth   = 20;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_enable = 1'b1;
  logic                  cfg_start_mode = 1'b0;
  logic [ToWidth-1:0]    cfg_timeout = '0;
  logic                  pkt_done_strobe = 1'b0;
  logic [15:0]           pkt_len = '0;
  logic                  fcs_ok = 1'b0;
  logic                  block_dec = 1'b0;
  logic                  block_dec_valid = 1'b0;
  logic                  trans_done = 1'b0;
  logic                  trans_start, trans_drop, trans_fcs_ok, busy, timeout_pulse;
  logic [13:0]           trans_num_words;
  logic [$clog2(DescDepth):0] pending_count;
  logic [7:0]            overflow_cnt;

  always #5 clk = ~clk;

  rx_dma_pkt_sched #(
    .DESC_DEPTH (DescDepth),
    .HDR_WORDS  (HdrWords),
    .TO_WIDTH   (ToWidth)
  ) dut (
    .m00_axis_aclk            (clk),
    .m00_axis_aresetn         (rst_n),
    .cfg_enable               (cfg_enable),
    .cfg_start_mode           (cfg_start_mode),
    .cfg_timeout              (cfg_timeout),
    .pkt_done_strobe          (pkt_done_strobe),
    .pkt_len                  (pkt_len),
    .fcs_ok                   (fcs_ok),
    .block_rx_dma_to_ps       (block_dec),
    .block_rx_dma_to_ps_valid (block_dec_valid),
    .trans_done               (trans_done),
    .trans_start              (trans_start),
    .trans_num_words          (trans_num_words),
    .trans_drop               (trans_drop),
    .trans_fcs_ok             (trans_fcs_ok),
    .pending_count            (pending_count),
    .busy                     (busy),
    .timeout_pulse            (timeout_pulse),
    .overflow_cnt             (overflow_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int len;
    bit ok;
  } desc_t;

  desc_t q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic int exp_words(input int len);
    return HdrWords + (len + 7) / 8;
  endfunction

  // Leaves the bench one cycle after the strobe cycle.
  task automatic push(input int len, input bit ok);
    pkt_done_strobe = 1'b1;
    pkt_len         = 16'(len);
    fcs_ok          = ok;
    cyc();
    pkt_done_strobe = 1'b0;
  endtask

  task automatic decide(input bit blk);
    block_dec_valid = 1'b1;
    block_dec       = blk;
    cyc();
    block_dec_valid = 1'b0;
  endtask

  task automatic finish_xfer();
    trans_done = 1'b1;
    cyc();
    trans_done = 1'b0;
  endtask

  initial begin
    bit   exp_start, done_now, active, due, en, st, ok;
    int   wcnt, ovf, len;
    desc_t d;

    cyc();
    cyc();
    check_eq("rst_start", trans_start, 0);
    check_eq("rst_drop", trans_drop, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pending", pending_count, 0);
    check_eq("rst_ovf", overflow_cnt, 0);
    check_eq("rst_timeout", timeout_pulse, 0);
    check_eq("rst_words", trans_num_words, 0);
    check_eq("rst_fcs", trans_fcs_ok, 0);
    rst_n = 1'b1;
    cyc();

    // Mode 0 launch latency and word count.
    cfg_start_mode = 1'b0;
    push(128, 1'b1);
    check_eq("t1_no_early_start", trans_start, 0);
    check_eq("t1_pending", pending_count, 1);
    cyc();
    check_eq("t1_start", trans_start, 1);
    check_eq("t1_words", trans_num_words, 18);
    check_eq("t1_fcs", trans_fcs_ok, 1);
    cyc();
    check_eq("t1_single_pulse", trans_start, 0);
    finish_xfer();
    check_eq("t1_idle", busy, 0);
    check_eq("t1_popped", pending_count, 0);

    // Mode 1 drop then forward.
    cfg_start_mode = 1'b1;
    push(100, 1'b1);
    cyc();
    check_eq("t2_wait_busy", busy, 1);
    check_eq("t2_wait_nostart", trans_start, 0);
    decide(1'b1);
    check_eq("t2_drop", trans_drop, 1);
    check_eq("t2_drop_nostart", trans_start, 0);
    cyc();
    check_eq("t2_drop_idle", busy, 0);
    check_eq("t2_drop_popped", pending_count, 0);
    push(100, 1'b1);
    cyc();
    decide(1'b0);
    check_eq("t2_fwd_start", trans_start, 1);
    check_eq("t2_fwd_words", trans_num_words, 15);
    check_eq("t2_fwd_nodrop", trans_drop, 0);
    cyc();
    finish_xfer();
    check_eq("t2_fwd_popped", pending_count, 0);

    // Early decision is latched and used.
    decide(1'b0);
    repeat (9) cyc();
    push(64, 1'b1);
    check_eq("t3_n1", trans_start, 0);
    cyc();
    check_eq("t3_n2", trans_start, 0);
    cyc();
    check_eq("t3_n3_start", trans_start, 1);
    check_eq("t3_words", trans_num_words, 10);
    cyc();
    finish_xfer();

    // Watchdog on a stalled transfer.
    cfg_start_mode = 1'b0;
    cfg_timeout    = ToWidth'(50);
    push(8, 1'b1);
    cyc();
    check_eq("t4_start", trans_start, 1);
    cyc();
    repeat (48) cyc();
    check_eq("t4_no_early_timeout", timeout_pulse, 0);
    cyc();
    check_eq("t4_timeout", timeout_pulse, 1);
    check_eq("t4_pending_before", pending_count, 1);
    cyc();
    check_eq("t4_idle", busy, 0);
    check_eq("t4_popped", pending_count, 0);
    check_eq("t4_pulse_once", timeout_pulse, 0);
    cfg_timeout = '0;

    // Overflow with launches held off, then FIFO-order drain.
    cfg_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pkt_done_strobe = 1'b1;
      pkt_len         = 16'((i + 1) * 8);
      fcs_ok          = 1'b1;
      cyc();
    end
    pkt_done_strobe = 1'b0;
    cyc();
    check_eq("t5_pending_full", pending_count, 4);
    check_eq("t5_ovf", overflow_cnt, 1);
    check_eq("t5_held", busy, 0);
    cfg_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 10; k++) begin
        if (trans_start) break;
        cyc();
      end
      check_eq("t5_launch_seen", trans_start, 1);
      check_eq("t5_order_words", trans_num_words, exp_words((i + 1) * 8));
      cyc();
      finish_xfer();
    end
    check_eq("t5_drained", pending_count, 0);

    // Bad-FCS handling in mode 1.
    cfg_start_mode = 1'b1;
    push(200, 1'b0);
    cyc();
`ifdef RX_DMA_SCHED_FCS_FILTER_EN
    check_eq("t6_filter_drop", trans_drop, 1);
    check_eq("t6_filter_nostart", trans_start, 0);
    cyc();
`else
    repeat (3) cyc();
    check_eq("t6_waits", busy, 1);
    check_eq("t6_no_drop", trans_drop, 0);
    check_eq("t6_fcs_out", trans_fcs_ok, 0);
    decide(1'b1);
    check_eq("t6_drop_after_dec", trans_drop, 1);
    cyc();
`endif
    check_eq("t6_idle", busy, 0);
    check_eq("t6_popped", pending_count, 0);

    // Randomized mode-0 traffic against a descriptor-queue model.
    cfg_start_mode = 1'b0;
    q.delete();
    active = 1'b0;
    due    = 1'b0;
    ovf    = 1;
    wcnt   = 0;
    for (int c = 0; c < 1500; c++) begin
      exp_start = due;
      due       = 1'b0;
      done_now  = 1'b0;
      check_eq("rnd_start", trans_start, exp_start);
      check_eq("rnd_drop", trans_drop, 0);
      check_eq("rnd_pending", pending_count, q.size());
      check_eq("rnd_ovf", overflow_cnt, ovf);
      if (exp_start) begin
        check_eq("rnd_words", trans_num_words, exp_words(q[0].len));
        check_eq("rnd_fcs", trans_fcs_ok, q[0].ok);
        active = 1'b1;
        wcnt   = $urandom_range(0, 4);
      end else if (active) begin
        if (wcnt == 0) done_now = 1'b1;
        else wcnt--;
      end
      check_eq("rnd_busy", busy, active);
      en = ($urandom_range(0, 9) != 0);
      if (!active && q.size() > 0 && en) due = 1'b1;
      st  = ($urandom_range(0, 2) == 0);
      len = $urandom_range(0, 65535);
      ok  = $urandom_range(0, 1) != 0;
`ifdef RX_DMA_SCHED_FCS_FILTER_EN
      ok = 1'b1;
`endif
      if (st) begin
        if (q.size() < int'(DescDepth)) begin
          d.len = len;
          d.ok  = ok;
          q.push_back(d);
        end else if (ovf < 255) begin
          ovf++;
        end
      end
      if (done_now) begin
        void'(q.pop_front());
        active = 1'b0;
      end
      pkt_done_strobe = st;
      pkt_len         = 16'(len);
      fcs_ok          = ok;
      trans_done      = done_now;
      cfg_enable      = en;
      cyc();
    end
    pkt_done_strobe = 1'b0;
    trans_done      = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
